// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full adder stepped LSB-first over WIDTH-bit operands.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds a 'sub' input).
module serial_adder_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             bit_sum;
   logic             carry_nxt;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   assign bit_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

   // Subtraction is A + ~B + 1, so only the loaded B and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~B : B;
   assign carry_load = sub ? 1'b1 : Cin;
`else
   assign b_load     = B;
   assign carry_load = Cin;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = A;
               b_sh_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = carry_nxt;
            s_sh_d  = {bit_sum, s_sh_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            // On the MSB step carry_q is the carry into the MSB.
            if (cnt_q == LAST_BIT) begin
               s_d     = {bit_sum, s_sh_q[WIDTH-1:1]};
               cout_d  = carry_nxt;
               ovf_d   = carry_q ^ carry_nxt;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign S    = s_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=4): vector table, random ops against
// an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;

   int total;
   int bad;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic             sub;
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
   } vec_t;

   vec_t vecs[8];

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout),
      .Ovf   (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a stuck DUT can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: plain integer arithmetic with signed-overflow rule.
   task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sb,
                           output logic [WIDTH-1:0] s, output logic cout,
                           output logic ovf);
      int ai, bi, ci, sum;
      int sa, sbv, ss;
      ai = int'(a);
      if (sb) begin
         bi = (1 << WIDTH) - 1 - int'(b);
         ci = 1;
      end else begin
         bi = int'(b);
         ci = int'(cin);
      end
      sum  = ai + bi + ci;
      s    = WIDTH'(sum % (1 << WIDTH));
      cout = (sum >= (1 << WIDTH));
      sa   = (ai  >= (1 << (WIDTH-1))) ? ai  - (1 << WIDTH) : ai;
      sbv  = (bi  >= (1 << (WIDTH-1))) ? bi  - (1 << WIDTH) : bi;
      ss   = sa + sbv + ci;
      ovf  = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
   endtask

   // Issues a one-cycle start, scrambles the operands right after acceptance,
   // then checks latency, busy span, result and the done pulse width.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sb,
                                input logic [WIDTH-1:0] exp_s, input logic exp_cout,
                                input logic exp_ovf, input string name);
      int n;
      int busy_cnt;
      @(negedge clk);
      A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
      n = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && n < 20) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         n++;
      end
      if (busy === 1'b1) busy_cnt++;
      checkOutput({name, " latency"}, n, WIDTH);
      checkOutput({name, " S"}, S, exp_s);
      checkOutput({name, " Cout"}, Cout, exp_cout);
      checkOutput({name, " Ovf"}, Ovf, exp_ovf);
      @(negedge clk);
      checkOutput({name, " busy span"}, busy_cnt, WIDTH + 1);
      checkOutput({name, " done width"}, done, 0);
      checkOutput({name, " busy end"}, busy, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb, es;
      logic             rc, rs, ec, eo;
      int               done_pos[$];
      int               done_seen;

      total = 0;
      bad   = 0;

      vecs[0] = '{a:4'd3,  b:4'd5,  cin:1'b0, sub:1'b0, s:4'd8,  cout:1'b0, ovf:1'b1};
      vecs[1] = '{a:4'd15, b:4'd1,  cin:1'b0, sub:1'b0, s:4'd0,  cout:1'b1, ovf:1'b0};
      vecs[2] = '{a:4'd7,  b:4'd8,  cin:1'b1, sub:1'b0, s:4'd0,  cout:1'b1, ovf:1'b0};
      vecs[3] = '{a:4'd1,  b:4'd1,  cin:1'b0, sub:1'b0, s:4'd2,  cout:1'b0, ovf:1'b0};
      vecs[4] = '{a:4'd0,  b:4'd0,  cin:1'b0, sub:1'b0, s:4'd0,  cout:1'b0, ovf:1'b0};
      vecs[5] = '{a:4'd15, b:4'd15, cin:1'b1, sub:1'b0, s:4'd15, cout:1'b1, ovf:1'b0};
      vecs[6] = '{a:4'd4,  b:4'd4,  cin:1'b0, sub:1'b0, s:4'd8,  cout:1'b0, ovf:1'b1};
      vecs[7] = '{a:4'd8,  b:4'd8,  cin:1'b0, sub:1'b0, s:4'd0,  cout:1'b1, ovf:1'b1};

      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset S", S, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] idle after reset");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle busy", busy, 0);
         checkOutput("idle done", done, 0);
         checkOutput("idle result", {S, Cout, Ovf}, 0);
      end

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                       vecs[i].s, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));
      end

`ifdef SERIAL_ADDER_SUB_EN
      $display("[TB] subtract vectors");
      applyStimulus(4'd5, 4'd3, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0, "sub 5-3");
      applyStimulus(4'd3, 4'd5, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0, "sub 3-5");
      applyStimulus(4'd8, 4'd1, 1'b0, 1'b1, 4'd7,  1'b1, 1'b1, "sub 8-1");
`endif

      $display("[TB] random operations");
      for (int i = 0; i < 16; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         refModel(ra, rb, rc, rs, es, ec, eo);
         applyStimulus(ra, rb, rc, rs, es, ec, eo, $sformatf("rand%0d", i));
      end

      // Start held high: one result per WIDTH+2 cycles, operand glitch mid-run ignored.
      $display("[TB] start held continuously");
      @(negedge clk);
      A = 4'd2; B = 4'd2; Cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 17; n++) begin
         if (n == 1) begin A = 4'd5; B = 4'd6; Cin = 1'b1; end
         if (n == 3) begin A = 4'd2; B = 4'd2; Cin = 1'b0; end
         if (done === 1'b1) begin
            done_pos.push_back(n);
            checkOutput($sformatf("held S at %0d", n), S, 4);
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("held done count", done_pos.size(), 3);
      if (done_pos.size() == 3) begin
         checkOutput("held first done", done_pos[0], WIDTH);
         checkOutput("held period a", done_pos[1] - done_pos[0], WIDTH + 2);
         checkOutput("held period b", done_pos[2] - done_pos[1], WIDTH + 2);
      end
      @(negedge clk);
      checkOutput("held back to idle", busy, 0);

      // Reset asserted during the second RUN bit aborts the operation.
      $display("[TB] abort with reset mid-run");
      applyStimulus(4'd6, 4'd7, 1'b0, 1'b0, 4'd13, 1'b0, 1'b1, "pre-abort");
      @(negedge clk);
      A = 4'd9; B = 4'd4; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort S", S, 0);
      checkOutput("abort Cout Ovf", {Cout, Ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checkOutput("abort no done", done_seen, 0);
      applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, "post-abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
